// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next PC from increment, branch target,
// interrupt vector or a circular return-address stack, with sticky stack flags.
module pc_sequencer #(
   parameter int                      PC_WIDTH    = 16,
   parameter int                      STACK_DEPTH = 4,
   parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0,
   parameter logic [PC_WIDTH-1:0]     INT_VECTOR  = 16'h0004,
   parameter logic [5:0]              OP_CALL     = 6'h01,
   parameter logic [5:0]              OP_SYSINT   = 6'h02,
   parameter logic [5:0]              OP_RET      = 6'h03
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          validin,
   input  logic                          stallin,
   input  logic [5:0]                    opin,
   input  logic                          MP0in,
   input  logic [PC_WIDTH-1:0]           targetin,
   output logic [PC_WIDTH-1:0]           pcout,
   output logic [$clog2(STACK_DEPTH):0]  depthout,
   output logic                          ovfout,
   output logic                          unfout
);

   localparam int PTR_W = $clog2(STACK_DEPTH);
   localparam logic [PTR_W:0] DEPTH_FULL = (PTR_W+1)'(STACK_DEPTH);

   logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];
   logic [PC_WIDTH-1:0] r_pc;
   logic [PTR_W-1:0]    r_wptr;
   logic [PTR_W:0]      r_depth;
   logic                r_ovf;
   logic                r_unf;

   logic                w_accept;
   logic                w_push;
   logic                w_pop;
   logic [PC_WIDTH-1:0] w_pcInc;
   logic [PTR_W-1:0]    w_topIdx;
   logic [PC_WIDTH-1:0] w_pcNext;
   logic [PTR_W-1:0]    w_wptrNext;
   logic [PTR_W:0]      w_depthNext;
   logic                w_ovfNext;
   logic                w_unfNext;

   assign w_accept = validin & ~stallin & rst_n;
   assign w_pcInc  = r_pc + 1'b1;
   assign w_topIdx = r_wptr - 1'b1;
   assign w_push   = w_accept & ((opin == OP_SYSINT) | (opin == OP_CALL));
   assign w_pop    = w_accept & (opin == OP_RET) & (r_depth != '0);

   // Opcode priority: sysint, call, ret, then branch select, then increment.
   always_comb begin
      w_pcNext    = r_pc;
      w_wptrNext  = r_wptr;
      w_depthNext = r_depth;
      w_ovfNext   = r_ovf;
      w_unfNext   = r_unf;
      if (w_accept) begin
         if (w_push) begin
            w_pcNext   = (opin == OP_SYSINT) ? INT_VECTOR : targetin;
            w_wptrNext = r_wptr + 1'b1;
            if (r_depth == DEPTH_FULL) begin
               w_ovfNext = 1'b1;
            end else begin
               w_depthNext = r_depth + 1'b1;
            end
         end else if (opin == OP_RET) begin
            if (w_pop) begin
               w_pcNext    = r_stack[w_topIdx];
               w_wptrNext  = w_topIdx;
               w_depthNext = r_depth - 1'b1;
            end else begin
               w_pcNext  = w_pcInc;
               w_unfNext = 1'b1;
            end
         end else if (MP0in) begin
            w_pcNext = targetin;
         end else begin
            w_pcNext = w_pcInc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc    <= RESET_PC;
         r_wptr  <= '0;
         r_depth <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_pc    <= w_pcNext;
         r_wptr  <= w_wptrNext;
         r_depth <= w_depthNext;
         r_ovf   <= w_ovfNext;
         r_unf   <= w_unfNext;
      end
   end

   // Stack storage carries no reset; a push onto a full stack simply
   // overwrites the oldest slot, which is the one the write pointer reaches.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_stack[r_wptr] <= w_pcInc;
      end
   end

   assign pcout    = r_pc;
   assign depthout = r_depth;
   assign ovfout   = r_ovf;
   assign unfout   = r_unf;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer sitting directly downstream of the branch-decision logic in the DataCycle datapath. Each accepted instruction selects the next PC from one of four sources: sequential increment, branch target when the branch-taken select MP0 is high, interrupt vector for `sysint`, or return-address stack top for `ret`. The block owns a small circular return-address stack: `call` and `sysint` push, `ret` pops. It also reports sticky overflow/underflow status.

## Interface
- PC_WIDTH, 16, width of PC, targets and stack entries
- STACK_DEPTH, 4, return-stack entries (power of two, ≥2)
- RESET_PC, 0, PC value loaded on reset
- INT_VECTOR, 16'h0004, target PC for `sysint`

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- validin  in  1  opin/MP0in/targetin describe an instruction this cycle
- stallin  in  1  hold all state; overrides validin
- opin  in  6  opcode; `call`, `sysint`, `ret` constants from Newdefine.h
- MP0in  in  1  branch-taken select from branch logic
- targetin  in  PC_WIDTH  branch/call target
- pcout  out  PC_WIDTH  current PC, registered
- depthout  out  log2(STACK_DEPTH)+1  valid stack entries
- ovfout  out  1  sticky: push onto full stack occurred
- unfout  out  1  sticky: pop from empty stack occurred

## Operation
- Accept = validin & ~stallin & rst_n. With no accept, all state holds: pcout, stack, depth, flags.
- On accept, the first matching rule applies:
  1. opin==`sysint`: push pcout+1; pcout ← INT_VECTOR. targetin is ignored.
  2. opin==`call`: push pcout+1; pcout ← targetin.
  3. opin==`ret`: pop; pcout ← popped value. If empty: pcout ← pcout+1, unfout ← 1, depth stays 0.
  4. MP0in==1: pcout ← targetin.
  5. else: pcout ← pcout+1.
- For `call`, `sysint` and `ret`, the opcode decides the action and MP0in is ignored.
- Stack is a circular buffer with a write pointer; depth saturates at STACK_DEPTH.
- Push when full: overwrites the oldest entry; ovfout ← 1; depth stays STACK_DEPTH. Subsequent pops return the newest STACK_DEPTH addresses in LIFO order.
- pcout+1 wraps modulo 2^PC_WIDTH: all-ones+1 = 0, no flag. Pushed return addresses wrap the same way.
- ovfout and unfout are cleared only by reset.

## Timing
- Reset (rst_n low at a rising edge): pcout=RESET_PC, depthout=0, ovfout=0, unfout=0, pointer=0. Stack contents are don't-care.
- Reset takes priority over validin and stallin.
- Reset asserted mid-sequence discards pending stack state at that same edge.
- Latency: an instruction accepted at edge N is reflected on pcout, depthout and flags immediately after edge N. There is no combinational path from inputs to outputs.
- Back-to-back accepts are supported every cycle, including call followed by ret; ret sees the pushed value with no bubble.
- stallin high for any number of cycles freezes the block exactly; the instruction is accepted on the first edge with stallin low and validin high.
- Throughput: one instruction per cycle.

## Test plan
- Reset and sequential: drive rst_n=0 for 2 cycles, then 3 accepted non-branch ops with MP0in=0 → pcout 0,1,2,3; depthout=0; flags=0.
- Branch and stall: at pc=3, assert MP0in=1, targetin=0x0100, stallin=1 for 2 cycles → pcout stays 3. Release stall → pcout=0x0100. A bubble with validin=0 holds pcout at 0x0100.
- Call/ret nesting: from pc=0x10, call 0x40, then call 0x80, then ret, then ret → pcout 0x40, 0x80, 0x41, 0x11; depthout 1, 2, 1, 0.
- sysint: at pc=0x20, accept sysint with targetin=0xFFFF and MP0in=1 → pcout=0x0004, depthout=1. Then ret → pcout=0x21.
- Overflow/underflow: perform 5 calls with STACK_DEPTH=4 → ovfout=1, depthout=4. Then 4 rets return the last 4 return addresses in LIFO order. A 5th ret → pcout=prev+1, unfout=1. Reset then clears both flags.
- Wrap: at pc=0xFFFF, accept a non-branch op → pcout=0x0000. A call at 0xFFFF pushes 0x0000, and the matching ret returns to 0x0000.
